// File: rtl/ysyx_22050612_mem_pkg.sv
// rtl/ysyx_22050612_mem_pkg.sv - shared encodings and defaults for the pmem arbiter
package ysyx_22050612_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// rtl/ysyx_22050612_rr_arb2.sv - two-way round-robin winner select
module ysyx_22050612_rr_arb2
    import ysyx_22050612_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    // bit 0 = fetch, bit 1 = load/store; on contention the side not served last wins
    always_comb begin
        grant = req;
        if (&req) begin
            grant = (last_grant == OWN_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// rtl/ysyx_22050612_mem_arbiter.sv - shares the pmem port between fetch and load/store
module ysyx_22050612_mem_arbiter
    import ysyx_22050612_mem_pkg::*;
#(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_resp_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req_valid,
    output logic          ls_req_ready,
    input  logic [AW-1:0] ls_addr,
    input  logic          ls_wen,
    input  logic [DW-1:0] ls_wdata,
    input  logic [7:0]    ls_wmask,
    output logic          ls_resp_valid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q;
    owner_e        owner_q;
    owner_e        last_grant_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_err_q;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    wmask_q;

    logic [1:0]    req;
    logic [1:0]    grant;
    logic          accept;
    logic          in_flight;
    logic          mem_done;
    logic          tmo;
    logic          resp_fire;
    logic [DW-1:0] resp_data;

    assign req = {ls_req_valid, if_req_valid};

    ysyx_22050612_rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept    = (state_q == ST_IDLE) && (|grant) && !rst;
    assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign mem_done  = mem_resp_valid &&
                       ((state_q == ST_WAIT) || ((state_q == ST_ISSUE) && mem_req_ready));
    // the cycle in which the counter would reach TIMEOUT is the abort cycle
    assign tmo       = in_flight && !mem_done && (cnt_q == CNT_LAST);
    assign resp_fire = (mem_done || tmo) && !rst;
    assign resp_data = (mem_done && !wen_q) ? mem_rdata : '0;

    assign if_req_ready  = accept && grant[0];
    assign ls_req_ready  = accept && grant[1];
    assign if_resp_valid = resp_fire && (owner_q == OWN_IF);
    assign ls_resp_valid = resp_fire && (owner_q == OWN_LS);
    assign if_rdata      = if_resp_valid ? resp_data : '0;
    assign ls_rdata      = ls_resp_valid ? resp_data : '0;

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_err   = timeout_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_IF;
            last_grant_q  <= OWN_IF;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            addr_q        <= '0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            wmask_q       <= '0;
        end else begin
            if (tmo) begin
                timeout_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q   <= '0;
                        state_q <= ST_ISSUE;
                        if (grant[1]) begin
                            owner_q      <= OWN_LS;
                            last_grant_q <= OWN_LS;
                            addr_q       <= ls_addr;
                            wen_q        <= ls_wen;
                            wdata_q      <= ls_wdata;
                            wmask_q      <= ls_wmask;
                        end else begin
                            owner_q      <= OWN_IF;
                            last_grant_q <= OWN_IF;
                            addr_q       <= if_addr;
                            wen_q        <= 1'b0;
                            wdata_q      <= '0;
                            wmask_q      <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (mem_done || tmo) begin
                        state_q <= ST_IDLE;
                    end else if (mem_req_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (mem_done || tmo) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// tb/tb_ysyx_22050612_mem_arbiter.sv - directed self-checking bench for the pmem arbiter
module tb_ysyx_22050612_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_addr = '0;
        ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        tick(); tick();
        settle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        chk("rst_mvalid", 64'(mem_req_valid), 64'd0);
        chk("rst_maddr", mem_addr, 64'd0);
        chk("rst_mwen", 64'(mem_wen), 64'd0);

        // fetch only, memory ready at once, response two cycles after issue
        tick();
        rst = 0;
        if_req_valid = 1; if_addr = 64'h8000_0000; mem_req_ready = 1;
        settle();
        chk("f_ready_c0", 64'(if_req_ready), 64'd1);
        chk("f_lsready_c0", 64'(ls_req_ready), 64'd0);
        tick();
        if_req_valid = 0;
        settle();
        chk("f_mvalid_c1", 64'(mem_req_valid), 64'd1);
        chk("f_maddr_c1", mem_addr, 64'h8000_0000);
        chk("f_mwmask_c1", 64'(mem_wmask), 64'd0);
        chk("f_ready_c1", 64'(if_req_ready), 64'd0);
        tick();
        settle();
        chk("f_mvalid_c2", 64'(mem_req_valid), 64'd0);
        chk("f_resp_c2", 64'(if_resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1; mem_rdata = 64'h0000_0413;
        settle();
        chk("f_resp_c3", 64'(if_resp_valid), 64'd1);
        chk("f_rdata_c3", if_rdata, 64'h0000_0413);
        chk("f_lsresp_c3", 64'(ls_resp_valid), 64'd0);
        tick();
        mem_resp_valid = 0;
        settle();
        chk("f_busy_c4", 64'(busy), 64'd0);
        chk("f_resp_c4", 64'(if_resp_valid), 64'd0);

        // both requesters pending: grants must go LS, IF, LS, IF
        if_req_valid = 1; if_addr = 64'h8000_0100;
        ls_req_valid = 1; ls_addr = 64'h8000_0200; ls_wen = 0;
        mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_ls;
            exp_ls = (i % 2 == 0);
            settle();
            chk("rr_lsready", 64'(ls_req_ready), 64'(exp_ls));
            chk("rr_ifready", 64'(if_req_ready), 64'(!exp_ls));
            tick();
            mem_resp_valid = 1;
            mem_rdata = (i == 0) ? 64'h1234 : 64'h100 + 64'(i);
            settle();
            chk("rr_ifready_iss", 64'(if_req_ready), 64'd0);
            chk("rr_lsready_iss", 64'(ls_req_ready), 64'd0);
            chk("rr_maddr", mem_addr, exp_ls ? 64'h8000_0200 : 64'h8000_0100);
            chk("rr_lsresp", 64'(ls_resp_valid), 64'(exp_ls));
            chk("rr_ifresp", 64'(if_resp_valid), 64'(!exp_ls));
            if (exp_ls) chk("rr_lsrdata", ls_rdata, (i == 0) ? 64'h1234 : 64'h100 + 64'(i));
            else        chk("rr_ifrdata", if_rdata, 64'h100 + 64'(i));
            tick();
            mem_resp_valid = 0;
        end
        if_req_valid = 0; ls_req_valid = 0;
        settle();
        chk("rr_idle", 64'(busy), 64'd0);

        // store with a three-cycle request stall
        ls_req_valid = 1; ls_addr = 64'h8000_1000; ls_wen = 1;
        ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F; mem_req_ready = 0;
        settle();
        chk("st_ready", 64'(ls_req_ready), 64'd1);
        tick();
        ls_req_valid = 0; ls_wdata = 64'h5555; ls_wmask = 8'hFF; ls_wen = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("st_mvalid", 64'(mem_req_valid), 64'd1);
            chk("st_mwen", 64'(mem_wen), 64'd1);
            chk("st_mwmask", 64'(mem_wmask), 64'h0F);
            chk("st_mwdata", mem_wdata, 64'hDEAD_BEEF);
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'hFFFF;
        settle();
        chk("st_resp", 64'(ls_resp_valid), 64'd1);
        chk("st_rdata", ls_rdata, 64'd0);
        tick();
        mem_resp_valid = 0;

        // memory never answers: abort on the 8th cycle after acceptance
        if_req_valid = 1; if_addr = 64'h8000_2000; mem_req_ready = 1; mem_rdata = 64'hABCD;
        settle();
        chk("to_ready", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid = 0;
        for (int c = 1; c < 8; c++) begin
            settle();
            chk("to_noresp", 64'(if_resp_valid), 64'd0);
            chk("to_noerr", 64'(timeout_err), 64'd0);
            tick();
        end
        settle();
        chk("to_resp", 64'(if_resp_valid), 64'd1);
        chk("to_rdata", if_rdata, 64'd0);
        tick();
        mem_resp_valid = 1;
        settle();
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_late", 64'(if_resp_valid), 64'd0);
        tick();
        mem_resp_valid = 0;
        settle();
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // reset during WAIT drops the transaction
        if_req_valid = 1; if_addr = 64'h8000_3000; mem_req_ready = 1;
        tick();
        if_req_valid = 0;
        tick();
        rst = 1;
        settle();
        chk("rw_noresp", 64'(if_resp_valid), 64'd0);
        tick();
        if_req_valid = 1; if_addr = 64'h8000_4000;
        settle();
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_terr", 64'(timeout_err), 64'd0);
        chk("rw_maddr", mem_addr, 64'd0);
        chk("rw_mvalid", 64'(mem_req_valid), 64'd0);
        chk("rw_noready", 64'(if_req_ready), 64'd0);
        chk("rw_noresp2", 64'(if_resp_valid), 64'd0);
        tick();
        rst = 0;
        settle();
        chk("rw_ready", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid = 0; mem_resp_valid = 1; mem_rdata = 64'h77;
        settle();
        chk("rw_maddr2", mem_addr, 64'h8000_4000);
        chk("rw_resp", 64'(if_resp_valid), 64'd1);
        chk("rw_rdata", if_rdata, 64'h77);
        tick();
        mem_resp_valid = 0;
        settle();
        chk("rw_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
